bit_stream_gen: RTL and testbench

BIT_STREAM_GEN -- requirements
Module: bit_stream_gen

---
 rtl/bitrec_pkg.sv | 11 +
 rtl/bit_stream_gen_if.sv | 11 +
 rtl/cell_timer.sv | 25 ++
 rtl/bit_stream_gen.sv | 84 ++++++++
 tb/tb_bit_stream_gen.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitrec_pkg.sv
// bitrec_pkg: shared FSM encoding, line-code constants and period helper for bit_stream_gen
package bitrec_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  localparam logic ENC_NRZ = 1'b0;
  localparam logic ENC_MANCHESTER = 1'b1;
  localparam int MIN_PERIOD_DEF = 2;
  // Periods below the floor would collapse the half-cell split to zero cycles.
  function automatic logic [15:0] clamp_period(input logic [15:0] p, input logic [15:0] min_p);
    return (p < min_p) ? min_p : p;
  endfunction
endpackage

// File: rtl/bit_stream_gen_if.sv
// bit_stream_gen_if: byte handshake between a producer and bit_stream_gen
//   tx_data  : byte to send, MSB first
//   tx_valid : tx_data valid
//   tx_ready : holding register empty; transfer on tx_valid && tx_ready
interface bit_stream_gen_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cell_timer.sv
// cell_timer: 16-bit down-counter marking the half point and end of each bit cell
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load the first cell of a frame from period
//   run        : frame in progress; counter decrements and reloads
//   period     : cell length P in clk cycles (P >= 2)
//   half_tick  : last cycle of the first half (P>>1 cycles)
//   cell_tick  : last cycle of the cell
module cell_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        run,
  input  logic [15:0] period,
  output logic        half_tick,
  output logic        cell_tick
);
  logic [15:0] cnt;
  // cnt holds the cycles left in the cell after this one, so it never needs P itself.
  assign cell_tick = run && cnt == 16'd0;
  assign half_tick = run && cnt == period - (period >> 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (start || cell_tick) cnt <= period - 16'd1;
    else if (run) cnt <= cnt - 16'd1;
endmodule

// File: rtl/bit_stream_gen.sv
// bit_stream_gen: serialises bytes as preamble + data frames in NRZ or Manchester
//   clk, rst_n  : clock, asynchronous active-low reset
//   bit_period  : cell length in clk cycles, latched at frame start
//   enc_type    : 0 = NRZ, 1 = Manchester, latched at frame start
//   bus         : byte handshake (tx_data, tx_valid, tx_ready)
//   signal_out  : registered serial line
//   bit_clk     : registered reference, high in the first half of each cell
//   busy        : frame in progress
module bit_stream_gen import bitrec_pkg::*; #(
  parameter int PREAMBLE_BITS = 32,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     bit_period,
  input  logic            enc_type,
  bit_stream_gen_if.slave bus,
  output logic            signal_out,
  output logic            bit_clk,
  output logic            busy
);
  state_t state, state_nxt;
  logic hold_full, enc_lat, second, start, run, load, half_tick, cell_tick;
  logic last_cell, boundary, move, cur_bit, line;
  logic [7:0] hold_q, shift_q;
  logic [15:0] p_in, p_lat, timer_p, cell_idx;
  assign bus.tx_ready = !hold_full;
  assign load = bus.tx_valid && !hold_full;
  assign run = state != IDLE;
  assign busy = run;
  assign start = state == IDLE && hold_full;
  assign p_in = clamp_period(bit_period, 16'(MIN_PERIOD));
  // The timer loads its first cell on the same edge that latches the period.
  assign timer_p = start ? p_in : p_lat;
  cell_timer u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .run(run),
    .period(timer_p),
    .half_tick(half_tick),
    .cell_tick(cell_tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    last_cell = (state == PREAMBLE) ? cell_idx == 16'(PREAMBLE_BITS - 1) : cell_idx == 16'd7;
    boundary = cell_tick && last_cell;
    move = boundary && hold_full;
    // Preamble alternates starting with 1; data goes out MSB first.
    cur_bit = (state == DATA) ? shift_q[7] : ~cell_idx[0];
    line = (enc_lat == ENC_MANCHESTER) ? cur_bit ^ second : cur_bit;
    state_nxt = state;
    if (start) state_nxt = PREAMBLE;
    else if (boundary) state_nxt = hold_full ? DATA : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_q <= '0;
      shift_q <= '0;
      p_lat <= '0;
      enc_lat <= ENC_NRZ;
      cell_idx <= '0;
      second <= 1'b0;
      signal_out <= 1'b0;
      bit_clk <= 1'b0;
    end else begin
      // A move empties the holding register before any same-cycle load refills it.
      hold_full <= load || (hold_full && !move);
      if (load) hold_q <= bus.tx_data;
      if (move) shift_q <= hold_q;
      else if (cell_tick && state == DATA) shift_q <= {shift_q[6:0], 1'b0};
      if (start) begin
        p_lat <= p_in;
        enc_lat <= enc_type;
      end
      cell_idx <= (start || boundary) ? '0 : cell_tick ? cell_idx + 16'd1 : cell_idx;
      second <= (start || cell_tick) ? 1'b0 : half_tick ? 1'b1 : second;
      signal_out <= run && line;
      bit_clk <= run && !second;
    end
endmodule

// File: tb/tb_bit_stream_gen.sv
// tb_bit_stream_gen: scoreboard bench for bit_stream_gen
module tb_bit_stream_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] bit_period = 16'd10;
  logic enc_type = 1'b0;
  logic signal_out, bit_clk, busy;
  int n_cmp = 0;
  int n_fail = 0;
  logic [1:0] sb[$];
  bit_stream_gen_if bus();
  bit_stream_gen #(.PREAMBLE_BITS(32), .MIN_PERIOD(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bit_period(bit_period),
    .enc_type(enc_type),
    .bus(bus),
    .signal_out(signal_out),
    .bit_clk(bit_clk),
    .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic push_cell(input int p, input logic enc, input logic v);
    int h = p >> 1;
    for (int i = 0; i < h; i++) sb.push_back({v, 1'b1});
    for (int i = h; i < p; i++) sb.push_back({enc ? ~v : v, 1'b0});
  endtask

  task automatic push_frame(input int p, input logic enc, input logic [23:0] bytes, input int n);
    logic [7:0] by;
    for (int i = 0; i < 32; i++) push_cell(p, enc, (i % 2) == 0);
    for (int k = 0; k < n; k++) begin
      by = bytes[23 - 8 * k -: 8];
      for (int b = 7; b >= 0; b--) push_cell(p, enc, by[b]);
    end
    sb.push_back(2'b00);
    sb.push_back(2'b00);
  endtask

  task automatic send(input string name, input logic [7:0] b, input logic last);
    int t = 0;
    logic r;
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    do begin
      r = bus.tx_ready;
      @(negedge clk);
      t++;
    end while (!r && t < 5000);
    if (last) bus.tx_valid = 1'b0;
    n_cmp++;
    if (!r || bus.tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handshake: accepted=%b tx_ready_after=%b want accepted=1 tx_ready_after=0", name, r, bus.tx_ready);
    end
  endtask

  task automatic check_frame(input string name, input int busy_exp);
    int t = 0;
    int nb = 0;
    int s = 0;
    logic [1:0] e;
    while (busy !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: busy=%b want 1", name, busy);
      sb.delete();
      return;
    end
    nb = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      s++;
      if (busy === 1'b1) nb++;
      n_cmp++;
      if ({signal_out, bit_clk} !== e) begin
        n_fail++;
        $display("FAIL %s sample %0d: signal_out,bit_clk=%b want %b", name, s, {signal_out, bit_clk}, e);
      end
    end
    n_cmp++;
    if (nb !== busy_exp) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d want %0d", name, nb, busy_exp);
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({signal_out, bit_clk, busy, bus.tx_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_hold: out,bclk,busy,ready=%b want 0001", {signal_out, bit_clk, busy, bus.tx_ready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({signal_out, bit_clk, busy, bus.tx_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release: out,bclk,busy,ready=%b want 0001", {signal_out, bit_clk, busy, bus.tx_ready});
    end
  endtask

  task automatic test_nrz_a5;
    bit_period = 16'd10;
    enc_type = 1'b0;
    push_frame(10, 1'b0, {8'hA5, 16'h0}, 1);
    fork
      send("nrz_a5", 8'hA5, 1'b1);
      check_frame("nrz_a5", 400);
    join
  endtask

  task automatic test_manchester;
    bit_period = 16'd7;
    enc_type = 1'b1;
    push_frame(7, 1'b1, {8'h0F, 16'h0}, 1);
    fork
      send("manch", 8'h0F, 1'b1);
      check_frame("manch", 280);
    join
  endtask

  task automatic test_back_to_back;
    bit_period = 16'd4;
    enc_type = 1'b0;
    push_frame(4, 1'b0, 24'h00FF3C, 3);
    fork
      begin
        send("b2b_0", 8'h00, 1'b0);
        send("b2b_1", 8'hFF, 1'b0);
        send("b2b_2", 8'h3C, 1'b1);
      end
      check_frame("b2b", 224);
    join
  endtask

  task automatic test_min_period;
    bit_period = 16'd0;
    enc_type = 1'b0;
    push_frame(2, 1'b0, {8'h96, 16'h0}, 1);
    fork
      send("per0", 8'h96, 1'b1);
      check_frame("per0", 80);
    join
    bit_period = 16'd1;
    enc_type = 1'b1;
    push_frame(2, 1'b1, {8'h69, 16'h0}, 1);
    fork
      send("per1", 8'h69, 1'b1);
      check_frame("per1", 80);
    join
  endtask

  task automatic test_period_change;
    bit_period = 16'd10;
    enc_type = 1'b0;
    push_frame(10, 1'b0, {8'h3C, 16'h0}, 1);
    fork
      send("chg_a", 8'h3C, 1'b1);
      check_frame("chg_a", 400);
      begin
        repeat (150) @(negedge clk);
        bit_period = 16'd20;
        enc_type = 1'b1;
      end
    join
    push_frame(20, 1'b1, {8'hC5, 16'h0}, 1);
    fork
      send("chg_b", 8'hC5, 1'b1);
      check_frame("chg_b", 800);
    join
  endtask

  task automatic test_reset_abort;
    int t = 0;
    bit_period = 16'd4;
    enc_type = 1'b0;
    fork
      begin
        send("abort_0", 8'hFF, 1'b0);
        send("abort_1", 8'h81, 1'b1);
      end
      begin
        while (busy !== 1'b1 && t < 400) begin
          @(negedge clk);
          t++;
        end
        repeat (141) @(negedge clk);
      end
    join
    n_cmp++;
    if ({signal_out, bit_clk, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL abort_bit3: out,bclk,busy=%b want 111", {signal_out, bit_clk, busy});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({signal_out, bit_clk, busy, bus.tx_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort_async: out,bclk,busy,ready=%b want 0001", {signal_out, bit_clk, busy, bus.tx_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, bus.tx_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_discard: busy,ready=%b want 01", {busy, bus.tx_ready});
    end
    push_frame(4, 1'b0, {8'h5A, 16'h0}, 1);
    fork
      send("restart", 8'h5A, 1'b1);
      check_frame("restart", 160);
    join
  endtask

  task automatic test_max_period;
    int t = 0;
    int nh = 0;
    int nb = 0;
    bit_period = 16'hFFFF;
    enc_type = 1'b0;
    fork
      send("pmax", 8'h55, 1'b1);
      begin
        while (busy !== 1'b1 && t < 400) begin
          @(negedge clk);
          t++;
        end
        @(negedge clk);
        while (signal_out === 1'b1 && nh < 70000) begin
          nh++;
          if (bit_clk === 1'b1) nb++;
          @(negedge clk);
        end
      end
    join
    n_cmp++;
    if (nh !== 65535) begin
      n_fail++;
      $display("FAIL pmax_cell: high for %0d cycles want 65535", nh);
    end
    n_cmp++;
    if (nb !== 32767) begin
      n_fail++;
      $display("FAIL pmax_half: bit_clk high %0d cycles want 32767", nb);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_nrz_a5();
    test_manchester();
    test_back_to_back();
    test_min_period();
    test_period_change();
    test_reset_abort();
    test_max_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
